// File: rtl/ps2_pkg.sv
// ============================================================================
// ps2_pkg : scan-code set 2 constants, command codes, frame FSM states
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package ps2_pkg;

  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_NUM0     = 8'h45;
  localparam logic [7:0] SC_NUM1     = 8'h16;
  localparam logic [7:0] SC_NUM2     = 8'h1E;
  localparam logic [7:0] SC_NUM3     = 8'h26;
  localparam logic [7:0] SC_R        = 8'h2D;
  localparam logic [7:0] SC_G        = 8'h34;
  localparam logic [7:0] SC_B        = 8'h32;
  localparam logic [7:0] SC_KP_PLUS  = 8'h79;
  localparam logic [7:0] SC_KP_MINUS = 8'h7B;
  localparam logic [7:0] SC_K        = 8'h42;
  localparam logic [7:0] SC_F        = 8'h2B;
  localparam logic [7:0] SC_UP       = 8'h75;
  localparam logic [7:0] SC_DOWN     = 8'h72;
  localparam logic [7:0] SC_LEFT     = 8'h6B;
  localparam logic [7:0] SC_RIGHT    = 8'h74;

  localparam logic [3:0] CMD_NUM0   = 4'h0;
  localparam logic [3:0] CMD_NUM1   = 4'h1;
  localparam logic [3:0] CMD_NUM2   = 4'h2;
  localparam logic [3:0] CMD_NUM3   = 4'h3;
  localparam logic [3:0] CMD_R      = 4'h4;
  localparam logic [3:0] CMD_G      = 4'h5;
  localparam logic [3:0] CMD_B      = 4'h6;
  localparam logic [3:0] CMD_UP     = 4'h7;
  localparam logic [3:0] CMD_DOWN   = 4'h8;
  localparam logic [3:0] CMD_LEFT   = 4'h9;
  localparam logic [3:0] CMD_RIGHT  = 4'hA;
  localparam logic [3:0] CMD_GROW   = 4'hB;
  localparam logic [3:0] CMD_SHRINK = 4'hC;
  localparam logic [3:0] CMD_BG     = 4'hD;
  localparam logic [3:0] CMD_FLASH  = 4'hE;
  localparam logic [3:0] CMD_IDLE   = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // Unmapped codes fall through to CMD_IDLE, which the top treats as "no command".
  function automatic logic [3:0] map_code(input logic [7:0] sc, input logic ext);
    logic [3:0] cmd;
    cmd = CMD_IDLE;
    if (ext) begin
      case (sc)
        SC_UP:    cmd = CMD_UP;
        SC_DOWN:  cmd = CMD_DOWN;
        SC_LEFT:  cmd = CMD_LEFT;
        SC_RIGHT: cmd = CMD_RIGHT;
        default:  cmd = CMD_IDLE;
      endcase
    end else begin
      case (sc)
        SC_NUM0:     cmd = CMD_NUM0;
        SC_NUM1:     cmd = CMD_NUM1;
        SC_NUM2:     cmd = CMD_NUM2;
        SC_NUM3:     cmd = CMD_NUM3;
        SC_R:        cmd = CMD_R;
        SC_G:        cmd = CMD_G;
        SC_B:        cmd = CMD_B;
        SC_KP_PLUS:  cmd = CMD_GROW;
        SC_KP_MINUS: cmd = CMD_SHRINK;
        SC_K:        cmd = CMD_BG;
        SC_F:        cmd = CMD_FLASH;
        default:     cmd = CMD_IDLE;
      endcase
    end
    return cmd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_rx_frame.sv
// ============================================================================
// ps2_rx_frame : PS/2 line synchronizer, falling-edge detect, frame FSM, watchdog
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] rxByte,
  output logic       rxValid,
  output logic       rxErr
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  rx_state_t              state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
  logic                   par_bit;
  logic [WD_W-1:0]        wd;

  logic fall;
  logic bit_in;
  logic timeout;
  logic stop_ok;

  // Synchronizers reset to 1 so an idle bus never looks like an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2Clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2Data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall    = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in  = data_sync[SYNC_STAGES-1];
  assign timeout = (state != IDLE) && (wd == WD_W'(TIMEOUT_CYCLES));
  assign stop_ok = bit_in & (^{shift, par_bit});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
      par_bit <= 1'b0;
      wd      <= '0;
    end else if (timeout) begin
      state <= IDLE;
      wd    <= '0;
    end else begin
      if (fall)
        wd <= '0;
      else if (state != IDLE)
        wd <= wd + WD_W'(1);

      if (fall) begin
        case (state)
          IDLE: begin
            if (!bit_in) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shift   <= {bit_in, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= PARITY;
          end
          PARITY: begin
            par_bit <= bit_in;
            state   <= STOP;
          end
          STOP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Strobes are decoded in the detect cycle; the top registers them for N+1 timing.
  assign rxByte  = shift;
  assign rxValid = fall & (state == STOP) & stop_ok & ~timeout;
  assign rxErr   = timeout | (fall & (state == STOP) & ~stop_ok);

endmodule

`default_nettype wire

// File: rtl/ps2_code_encoder.sv
// ============================================================================
// ps2_code_encoder : PS/2 scan codes to one-cycle 4-bit VGA command codes
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_code_encoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [3:0] inCode,
  output logic       codeStrobe,
  output logic       frameErr
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic       brk;
  logic       ext;
  logic [3:0] cmd;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rx (
    .clock   (clock),
    .reset   (reset),
    .ps2Clk  (ps2Clk),
    .ps2Data (ps2Data),
    .rxByte  (rx_byte),
    .rxValid (rx_valid),
    .rxErr   (rx_err)
  );

  assign cmd = map_code(rx_byte, ext);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inCode     <= CMD_IDLE;
      codeStrobe <= 1'b0;
      frameErr   <= 1'b0;
      brk        <= 1'b0;
      ext        <= 1'b0;
    end else begin
      inCode     <= CMD_IDLE;
      codeStrobe <= 1'b0;
      frameErr   <= rx_err;
      if (rx_err) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (rx_valid) begin
        if (rx_byte == SC_BREAK) begin
          brk <= 1'b1;
        end else if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else begin
          // Release codes consume the prefixes without emitting a command.
          brk <= 1'b0;
          ext <= 1'b0;
          if (!brk) begin
            inCode     <= cmd;
            codeStrobe <= (cmd != CMD_IDLE);
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_code_encoder.sv
// ============================================================================
// tb_ps2_code_encoder : random + directed PS/2 frames against a keymap model
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_code_encoder;

  localparam int TO = 400;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic       ps2Clk  = 1'b1;
  logic       ps2Data = 1'b1;
  logic [3:0] inCode;
  logic       codeStrobe;
  logic       frameErr;

  int n_cmp = 0;
  int n_bad = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int incons = 0;

  bit m_brk = 1'b0;
  bit m_ext = 1'b0;
  logic [3:0] key_tbl [logic [8:0]];

  always #5 clock = ~clock;

  ps2_code_encoder #(
    .TIMEOUT_CYCLES (TO),
    .SYNC_STAGES    (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ps2Clk     (ps2Clk),
    .ps2Data    (ps2Data),
    .inCode     (inCode),
    .codeStrobe (codeStrobe),
    .frameErr   (frameErr)
  );

  always @(negedge clock) begin
    if (!reset) begin
      if (codeStrobe) strobe_cnt++;
      if (frameErr) err_cnt++;
      if (codeStrobe !== (inCode != 4'hF)) incons++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_cmd(input bit ext, input logic [7:0] b);
    if (key_tbl.exists({ext, b})) return key_tbl[{ext, b}];
    return 4'hF;
  endfunction

  task automatic ps2_bit(input logic v);
    ps2Data = v;
    repeat (4) @(negedge clock);
    ps2Clk = 1'b0;
    repeat (8) @(negedge clock);
    ps2Clk = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  // Output is sampled on the third negedge after the stop-bit falling edge is driven.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            output logic [3:0] code3, output logic err3);
    logic par;
    par = ~(^b) ^ bad_par;
    code3 = 4'hF;
    err3  = 1'b0;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2Data = ~bad_stop;
    repeat (4) @(negedge clock);
    ps2Clk = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 3) begin
        code3 = inCode;
        err3  = frameErr;
      end
    end
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int s0, e0;
    logic [3:0] c, exp_c;
    logic e;
    bit exp_e;
    s0 = strobe_cnt;
    e0 = err_cnt;
    send_frame(b, bad_par, bad_stop, c, e);
    exp_c = 4'hF;
    exp_e = bad_par | bad_stop;
    if (exp_e) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else begin
      if (!m_brk) exp_c = ref_cmd(m_ext, b);
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
    check({tag, ":code"}, 32'(c), 32'(exp_c));
    check({tag, ":err"}, 32'(e), 32'(exp_e));
    check({tag, ":npulse"}, strobe_cnt - s0, (exp_c != 4'hF) ? 1 : 0);
    check({tag, ":nerr"}, err_cnt - e0, exp_e ? 1 : 0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] pool [17];
    logic [7:0] b;
    int s0, e0;

    key_tbl[{1'b0, 8'h45}] = 4'h0; key_tbl[{1'b0, 8'h16}] = 4'h1;
    key_tbl[{1'b0, 8'h1E}] = 4'h2; key_tbl[{1'b0, 8'h26}] = 4'h3;
    key_tbl[{1'b0, 8'h2D}] = 4'h4; key_tbl[{1'b0, 8'h34}] = 4'h5;
    key_tbl[{1'b0, 8'h32}] = 4'h6; key_tbl[{1'b0, 8'h79}] = 4'hB;
    key_tbl[{1'b0, 8'h7B}] = 4'hC; key_tbl[{1'b0, 8'h42}] = 4'hD;
    key_tbl[{1'b0, 8'h2B}] = 4'hE;
    key_tbl[{1'b1, 8'h75}] = 4'h7; key_tbl[{1'b1, 8'h72}] = 4'h8;
    key_tbl[{1'b1, 8'h6B}] = 4'h9; key_tbl[{1'b1, 8'h74}] = 4'hA;
    pool = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h2D, 8'h34, 8'h32, 8'h79, 8'h7B,
             8'h42, 8'h2B, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hF0, 8'hE0};

    repeat (3) @(negedge clock);
    check("rst:code", 32'(inCode), 32'hF);
    check("rst:strobe", 32'(codeStrobe), 0);
    check("rst:err", 32'(frameErr), 0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    do_frame("single16", 8'h16, 1'b0, 1'b0);
    do_frame("mk2B", 8'h2B, 1'b0, 1'b0);
    do_frame("brkF0", 8'hF0, 1'b0, 1'b0);
    do_frame("brk2B", 8'h2B, 1'b0, 1'b0);
    do_frame("extE0", 8'hE0, 1'b0, 1'b0);
    do_frame("ext75", 8'h75, 1'b0, 1'b0);
    do_frame("xbE0", 8'hE0, 1'b0, 1'b0);
    do_frame("xbF0", 8'hF0, 1'b0, 1'b0);
    do_frame("xb75", 8'h75, 1'b0, 1'b0);
    do_frame("plain75", 8'h75, 1'b0, 1'b0);
    do_frame("par45", 8'h45, 1'b1, 1'b0);
    do_frame("good45", 8'h45, 1'b0, 1'b0);
    do_frame("stopE0", 8'hE0, 1'b0, 1'b0);
    do_frame("badstop", 8'h74, 1'b0, 1'b1);
    do_frame("after_stop74", 8'h74, 1'b0, 1'b0);

    // Timeout after a pending E0 must also drop the prefix.
    do_frame("toE0", 8'hE0, 1'b0, 1'b0);
    s0 = strobe_cnt;
    e0 = err_cnt;
    b  = 8'h1E;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(b[i]);
    repeat (TO + 2) @(negedge clock);
    check("timeout:nerr", err_cnt - e0, 1);
    check("timeout:npulse", strobe_cnt - s0, 0);
    m_brk = 1'b0;
    m_ext = 1'b0;
    do_frame("to75", 8'h75, 1'b0, 1'b0);
    do_frame("to1E", 8'h1E, 1'b0, 1'b0);

    // Reset in the middle of an E0 frame.
    b = 8'hE0;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(b[i]);
    reset = 1'b1;
    s0 = strobe_cnt;
    e0 = err_cnt;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("inrst:code", 32'(inCode), 32'hF);
      check("inrst:strobe", 32'(codeStrobe), 0);
      check("inrst:err", 32'(frameErr), 0);
    end
    reset = 1'b0;
    m_brk = 1'b0;
    m_ext = 1'b0;
    repeat (20) @(negedge clock);
    check("postrst:npulse", strobe_cnt - s0, 0);
    check("postrst:nerr", err_cnt - e0, 0);
    do_frame("rst74", 8'h74, 1'b0, 1'b0);

    for (int n = 0; n < 70; n++) begin
      int idx;
      bit bp, bs;
      idx = $urandom_range(0, 17);
      b   = (idx == 17) ? 8'($urandom) : pool[idx];
      bp  = ($urandom_range(0, 9) == 0);
      bs  = !bp && ($urandom_range(0, 19) == 0);
      do_frame("rand", b, bp, bs);
    end

    check("strobe_vs_code", incons, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
